// File: rtl/bitnet_pkg.sv
// Shared types and helpers for the binary-network datapath:
// default lane geometry, vote words and the weighted XNOR vote.
package bitnet_pkg;

  localparam int LANES_DEF     = 8;
  localparam int MAX_WORDS_DEF = 16;

  typedef logic [LANES_DEF-1:0] vote_word_t;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } accum_state_t;

  // A lane counts as a match when the vote agrees with its weight bit.
  function automatic vote_word_t xnor_vote(input vote_word_t vote, input vote_word_t weight);
    return ~(vote ^ weight);
  endfunction

endpackage

// File: rtl/popcount_tree.sv
// Combinational population count of a WIDTH-bit word, result in $clog2(WIDTH+1) bits.
module popcount_tree #(
  parameter int WIDTH = 8,
  parameter int OUT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] bits,
  output logic [OUT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + OUT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/maj_vote_accum.sv
// Sequential majority-vote neuron: accumulates weighted vote matches over a packet
// and emits one thresholded vote plus the raw count per packet.
module maj_vote_accum
  import bitnet_pkg::*;
#(
  parameter int LANES     = LANES_DEF,
  parameter int MAX_WORDS = MAX_WORDS_DEF,
  parameter int CNT_W     = $clog2(LANES * MAX_WORDS + 1)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             s_valid_in,
  output logic             s_ready_out,
  input  logic [LANES-1:0] s_votes_in,
  input  logic [LANES-1:0] s_weights_in,
  input  logic             s_last_in,
  input  logic [CNT_W-1:0] thresh_in,
  output logic             m_valid_out,
  input  logic             m_ready_in,
  output logic             m_vote_out,
  output logic [CNT_W-1:0] m_count_out,
  output logic             m_overflow_out
);

  localparam int PC_W = $clog2(LANES + 1);
  localparam int WC_W = $clog2(MAX_WORDS + 1);

  accum_state_t     state, state_nxt;
  logic [CNT_W-1:0] acc, thr, sum, thr_eff;
  logic [WC_W-1:0]  word_cnt;
  logic             first;
  logic [LANES-1:0] match;
  logic [PC_W-1:0]  pc;
  logic             accept, pkt_end;

  assign match = xnor_vote(s_votes_in, s_weights_in);

  popcount_tree #(.WIDTH(LANES), .OUT_W(PC_W)) u_popcount (
    .bits  (match),
    .count (pc)
  );

  assign s_ready_out = (state == ACCUM) && !rst_in;
  assign accept      = s_valid_in && s_ready_out;
  assign pkt_end     = s_last_in || (word_cnt == WC_W'(MAX_WORDS - 1));
  // The first word of a packet both seeds the sum and supplies the threshold.
  assign sum         = (first ? '0 : acc) + CNT_W'(pc);
  assign thr_eff     = first ? thresh_in : thr;

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: if (accept && pkt_end) state_nxt = HOLD;
      HOLD:  if (m_ready_in)        state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= ACCUM;
      acc            <= '0;
      word_cnt       <= '0;
      thr            <= '0;
      first          <= 1'b1;
      m_valid_out    <= 1'b0;
      m_vote_out     <= 1'b0;
      m_count_out    <= '0;
      m_overflow_out <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (first) begin
          thr   <= thresh_in;
          first <= 1'b0;
        end
        if (pkt_end) begin
          m_count_out    <= sum;
          m_vote_out     <= (sum >= thr_eff);
          m_overflow_out <= ~s_last_in;
          m_valid_out    <= 1'b1;
          acc            <= '0;
          word_cnt       <= '0;
          first          <= 1'b1;
        end else begin
          acc      <= sum;
          word_cnt <= word_cnt + 1'b1;
        end
      end else if (state == HOLD && m_ready_in) begin
        m_valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_maj_vote_accum.sv
// Directed self-checking bench for maj_vote_accum with hand-computed expectations.
module tb_maj_vote_accum;

  localparam int CNT_W = 8;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             s_valid_in;
  logic             s_ready_out;
  logic [7:0]       s_votes_in;
  logic [7:0]       s_weights_in;
  logic             s_last_in;
  logic [CNT_W-1:0] thresh_in;
  logic             m_valid_out;
  logic             m_ready_in;
  logic             m_vote_out;
  logic [CNT_W-1:0] m_count_out;
  logic             m_overflow_out;

  int checks = 0;
  int fails  = 0;

  maj_vote_accum dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .s_valid_in     (s_valid_in),
    .s_ready_out    (s_ready_out),
    .s_votes_in     (s_votes_in),
    .s_weights_in   (s_weights_in),
    .s_last_in      (s_last_in),
    .thresh_in      (thresh_in),
    .m_valid_out    (m_valid_out),
    .m_ready_in     (m_ready_in),
    .m_vote_out     (m_vote_out),
    .m_count_out    (m_count_out),
    .m_overflow_out (m_overflow_out)
  );

  always #5 clk_in = ~clk_in;

  // Present one word for exactly one edge; inputs and samples sit 1 time unit after the edge.
  task automatic send_word(input logic [7:0] v, input logic [7:0] w, input logic last,
                           input logic [CNT_W-1:0] th);
    s_votes_in   = v;
    s_weights_in = w;
    s_last_in    = last;
    thresh_in    = th;
    s_valid_in   = 1'b1;
    @(posedge clk_in);
    #1;
    s_valid_in = 1'b0;
    s_last_in  = 1'b0;
  endtask

  task automatic accept_result();
    m_ready_in = 1'b1;
    @(posedge clk_in);
    #1;
    m_ready_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    checks++;
    if (s_ready_out !== 1'b0) begin fails++; $display("[TB] FAIL reset_ready_low got %b want 0", s_ready_out); end
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;
    checks++;
    if (s_ready_out !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready_high got %b want 1", s_ready_out); end
    checks++;
    if (m_valid_out !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid got %b want 0", m_valid_out); end
    checks++;
    if (m_count_out !== 8'd0) begin fails++; $display("[TB] FAIL reset_count got %0d want 0", m_count_out); end
  endtask

  task automatic test_tie();
    send_word(8'hFF, 8'hFF, 1'b0, 8'd12);
    checks++;
    if (m_valid_out !== 1'b0) begin fails++; $display("[TB] FAIL tie_midvalid got %b want 0", m_valid_out); end
    send_word(8'h0F, 8'hFF, 1'b1, 8'd0);
    checks++;
    if (m_valid_out !== 1'b1 || m_count_out !== 8'd12 || m_vote_out !== 1'b1 || m_overflow_out !== 1'b0) begin
      fails++;
      $display("[TB] FAIL tie_result got v=%b c=%0d vote=%b ov=%b want v=1 c=12 vote=1 ov=0",
               m_valid_out, m_count_out, m_vote_out, m_overflow_out);
    end
    accept_result();
    checks++;
    if (m_valid_out !== 1'b0 || s_ready_out !== 1'b1) begin
      fails++; $display("[TB] FAIL tie_release got v=%b rdy=%b want v=0 rdy=1", m_valid_out, s_ready_out);
    end
  endtask

  task automatic test_hold();
    send_word(8'hFF, 8'hFF, 1'b0, 8'd13);
    send_word(8'h0F, 8'hFF, 1'b1, 8'd13);
    checks++;
    if (m_count_out !== 8'd12 || m_vote_out !== 1'b0) begin
      fails++; $display("[TB] FAIL hold_result got c=%0d vote=%b want c=12 vote=0", m_count_out, m_vote_out);
    end
    // Offer a word while holding; it must be ignored.
    s_votes_in = 8'hFF; s_weights_in = 8'hFF; s_last_in = 1'b1; thresh_in = 8'd0; s_valid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_in);
      #1;
      checks++;
      if (m_valid_out !== 1'b1 || m_count_out !== 8'd12 || m_vote_out !== 1'b0 || s_ready_out !== 1'b0) begin
        fails++;
        $display("[TB] FAIL hold_stable[%0d] got v=%b c=%0d vote=%b rdy=%b want v=1 c=12 vote=0 rdy=0",
                 i, m_valid_out, m_count_out, m_vote_out, s_ready_out);
      end
    end
    s_valid_in = 1'b0; s_last_in = 1'b0;
    accept_result();
    checks++;
    if (m_valid_out !== 1'b0) begin fails++; $display("[TB] FAIL hold_drop got %b want 0", m_valid_out); end
  endtask

  task automatic test_invert();
    send_word(8'h00, 8'h00, 1'b1, 8'd8);
    checks++;
    if (m_valid_out !== 1'b1 || m_count_out !== 8'd8 || m_vote_out !== 1'b1) begin
      fails++; $display("[TB] FAIL invert_single got v=%b c=%0d vote=%b want v=1 c=8 vote=1",
                        m_valid_out, m_count_out, m_vote_out);
    end
    accept_result();
    send_word(8'hFF, 8'hFF, 1'b0, 8'd25);
    send_word(8'hFF, 8'hFF, 1'b0, 8'd0);
    send_word(8'hFF, 8'hFF, 1'b1, 8'd0);
    checks++;
    if (m_count_out !== 8'd24 || m_vote_out !== 1'b0) begin
      fails++; $display("[TB] FAIL invert_midthresh got c=%0d vote=%b want c=24 vote=0", m_count_out, m_vote_out);
    end
    accept_result();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 15; i++) send_word(8'h01, 8'hFF, 1'b0, (i == 0) ? 8'd16 : 8'd200);
    checks++;
    if (m_valid_out !== 1'b0) begin fails++; $display("[TB] FAIL ovf_early got v=%b want 0", m_valid_out); end
    send_word(8'h01, 8'hFF, 1'b0, 8'd200);
    checks++;
    if (m_valid_out !== 1'b1 || m_count_out !== 8'd16 || m_vote_out !== 1'b1 || m_overflow_out !== 1'b1) begin
      fails++;
      $display("[TB] FAIL ovf_cut got v=%b c=%0d vote=%b ov=%b want v=1 c=16 vote=1 ov=1",
               m_valid_out, m_count_out, m_vote_out, m_overflow_out);
    end
    accept_result();
    send_word(8'hFF, 8'hFF, 1'b1, 8'd8);
    checks++;
    if (m_count_out !== 8'd8 || m_vote_out !== 1'b1 || m_overflow_out !== 1'b0) begin
      fails++; $display("[TB] FAIL ovf_next got c=%0d vote=%b ov=%b want c=8 vote=1 ov=0",
                        m_count_out, m_vote_out, m_overflow_out);
    end
    accept_result();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) send_word(8'hFF, 8'hFF, 1'b0, 8'd0);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    checks++;
    if (m_valid_out !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_valid got %b want 0", m_valid_out); end
    @(posedge clk_in);
    #1;
    send_word(8'h07, 8'hFF, 1'b1, 8'd2);
    checks++;
    if (m_valid_out !== 1'b1 || m_count_out !== 8'd3 || m_vote_out !== 1'b1) begin
      fails++; $display("[TB] FAIL rstmid_next got v=%b c=%0d vote=%b want v=1 c=3 vote=1",
                        m_valid_out, m_count_out, m_vote_out);
    end
    accept_result();
  endtask

  task automatic test_thresh_edges();
    send_word(8'hFF, 8'h00, 1'b1, 8'd0);
    checks++;
    if (m_count_out !== 8'd0 || m_vote_out !== 1'b1) begin
      fails++; $display("[TB] FAIL thr_zero got c=%0d vote=%b want c=0 vote=1", m_count_out, m_vote_out);
    end
    accept_result();
    send_word(8'hFF, 8'hFF, 1'b1, 8'd200);
    checks++;
    if (m_count_out !== 8'd8 || m_vote_out !== 1'b0) begin
      fails++; $display("[TB] FAIL thr_high got c=%0d vote=%b want c=8 vote=0", m_count_out, m_vote_out);
    end
    accept_result();
  endtask

  initial begin
    rst_in = 1'b1; s_valid_in = 1'b0; s_votes_in = '0; s_weights_in = '0;
    s_last_in = 1'b0; thresh_in = '0; m_ready_in = 1'b0;
    test_reset();
    test_tie();
    test_hold();
    test_invert();
    test_overflow();
    test_reset_mid();
    test_thresh_edges();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
